// File: rtl/cal_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : cal_serial_tx
// Purpose  : Transmitter end of the 3-wire sensor calibration interface
//            (CAL_CLK / CAL_DAT / CAL_ENA). Captures a parallel word on an
//            accepted start request and shifts it out MSB-first, with the
//            serial clock derived from the system clock.
// Ports    : i_clk      - system clock, rising edge
//            i_rst_n    - asynchronous active-low reset
//            i_start    - single-cycle request, honoured only while idle
//            i_data     - word to send, captured when i_start is accepted
//            o_busy     - frame in progress (SETUP through last HOLD cycle)
//            o_done     - one-cycle pulse in the first idle cycle after a frame
//            o_cal_clk  - serial clock to the sensor
//            o_cal_dat  - serial data, stable across each o_cal_clk rise
//            o_cal_ena  - frame enable
// Options  : CAL_PARITY_EN - when defined, an even-parity bit (XOR of all
//            data bits) is sent after the LSB.
// Revision : 1.0 - initial release
// ============================================================================
module cal_serial_tx #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_cal_clk,
    output logic              o_cal_dat,
    output logic              o_cal_ena
);

`ifdef CAL_PARITY_EN
    localparam int c_n_bits = DATA_W + 1;
`else
    localparam int c_n_bits = DATA_W;
`endif
    localparam int c_bc_w = $clog2(c_n_bits + 1);
    // A divider of 1 would give a zero-width counter; keep one bit.
    localparam int c_ph_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_ph_w-1:0] c_ph_last = c_ph_w'(CLK_DIV - 1);
    localparam logic [c_bc_w-1:0] c_bc_load = c_bc_w'(c_n_bits);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t              r_state;
    logic [c_ph_w-1:0]   r_phase;
    logic [c_bc_w-1:0]   r_bitcnt;
    // One spare zero bit below the frame so the "next bit" index stays
    // legal even for a single-bit frame.
    logic [c_n_bits:0]   r_shift;
    logic                r_busy;
    logic                r_done;
    logic                r_cal_clk;
    logic                r_cal_dat;
    logic                r_cal_ena;

    logic [c_n_bits-1:0] w_frame;
    logic                w_ph_end;

`ifdef CAL_PARITY_EN
    assign w_frame = {i_data, ^i_data};
`else
    assign w_frame = i_data;
`endif

    assign w_ph_end = (r_phase == c_ph_last);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_phase   <= '0;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cal_clk <= 1'b0;
            r_cal_dat <= 1'b0;
            r_cal_ena <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_phase <= '0;
                    if (i_start) begin
                        r_state   <= S_SETUP;
                        r_shift   <= {w_frame, 1'b0};
                        r_bitcnt  <= c_bc_load;
                        r_busy    <= 1'b1;
                        r_cal_ena <= 1'b1;
                        r_cal_clk <= 1'b0;
                        r_cal_dat <= w_frame[c_n_bits-1];
                    end
                end
                S_SETUP: begin
                    if (w_ph_end) begin
                        r_phase   <= '0;
                        r_state   <= S_HIGH;
                        r_cal_clk <= 1'b1;
                        r_bitcnt  <= r_bitcnt - c_bc_w'(1);
                    end else begin
                        r_phase <= r_phase + c_ph_w'(1);
                    end
                end
                S_HIGH: begin
                    if (w_ph_end) begin
                        r_phase   <= '0;
                        r_cal_clk <= 1'b0;
                        if (r_bitcnt != '0) begin
                            // Data moves on the falling edge, half a
                            // serial period ahead of the next rise.
                            r_state   <= S_LOW;
                            r_shift   <= r_shift << 1;
                            r_cal_dat <= r_shift[c_n_bits-1];
                        end else begin
                            r_state <= S_HOLD;
                        end
                    end else begin
                        r_phase <= r_phase + c_ph_w'(1);
                    end
                end
                S_LOW: begin
                    if (w_ph_end) begin
                        r_phase   <= '0;
                        r_state   <= S_HIGH;
                        r_cal_clk <= 1'b1;
                        r_bitcnt  <= r_bitcnt - c_bc_w'(1);
                    end else begin
                        r_phase <= r_phase + c_ph_w'(1);
                    end
                end
                S_HOLD: begin
                    if (w_ph_end) begin
                        r_phase   <= '0;
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_cal_ena <= 1'b0;
                        r_cal_dat <= 1'b0;
                    end else begin
                        r_phase <= r_phase + c_ph_w'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_phase <= '0;
                end
            endcase
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_cal_clk = r_cal_clk;
    assign o_cal_dat = r_cal_dat;
    assign o_cal_ena = r_cal_ena;

endmodule
`default_nettype wire

// File: tb/tb_cal_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_cal_serial_tx
// Purpose  : Self-checking bench for cal_serial_tx. Two instances share the
//            clock and reset: dut0 with CLK_DIV=4, dut1 with CLK_DIV=1.
//            A pin-level monitor reassembles received bits, frame lengths,
//            enable gaps and DONE pulses; expectations come from the frame
//            rules (bit order, parity, length formula).
// Options  : CAL_PARITY_EN - expectations follow the parity build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cal_serial_tx;

    localparam int DW = 16;
`ifdef CAL_PARITY_EN
    localparam int NB = DW + 1;
`else
    localparam int NB = DW;
`endif
    localparam int DIV0 = 4;
    localparam int DIV1 = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start0 = 1'b0;
    logic          start1 = 1'b0;
    logic [DW-1:0] data = '0;
    logic          mon_clr = 1'b0;

    logic w_busy [2];
    logic w_done [2];
    logic w_cck  [2];
    logic w_dat  [2];
    logic w_ena  [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cal_serial_tx #(.DATA_W(DW), .CLK_DIV(DIV0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start0), .i_data(data),
        .o_busy(w_busy[0]), .o_done(w_done[0]), .o_cal_clk(w_cck[0]),
        .o_cal_dat(w_dat[0]), .o_cal_ena(w_ena[0])
    );

    cal_serial_tx #(.DATA_W(DW), .CLK_DIV(DIV1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_data(data),
        .o_busy(w_busy[1]), .o_done(w_done[1]), .o_cal_clk(w_cck[1]),
        .o_cal_dat(w_dat[1]), .o_cal_ena(w_ena[1])
    );

    // ---------------- pin-level monitor (sampled on falling edge) ----------
    int          rises [2];
    int          ena_run [2];
    int          last_run [2];
    int          low_run [2];
    int          last_gap [2];
    int          dones [2];
    int          stab_err [2];
    logic [63:0] rx [2];
    logic        p_cck [2];
    logic        p_dat [2];
    logic        p_ena [2];

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (mon_clr) begin
                rises[g] = 0; ena_run[g] = 0; last_run[g] = 0;
                low_run[g] = 0; last_gap[g] = 0; dones[g] = 0;
                stab_err[g] = 0; rx[g] = '0;
            end else begin
                if (w_cck[g] && !p_cck[g]) begin
                    rises[g]++;
                    rx[g] = {rx[g][62:0], w_dat[g]};
                    if (w_dat[g] !== p_dat[g]) stab_err[g]++;
                end
                if (w_ena[g]) begin
                    ena_run[g]++;
                    if (!p_ena[g]) begin
                        last_gap[g] = low_run[g];
                        low_run[g] = 0;
                    end
                end else begin
                    low_run[g]++;
                    if (p_ena[g]) begin
                        last_run[g] = ena_run[g];
                        ena_run[g] = 0;
                    end
                end
                if (w_done[g]) dones[g]++;
            end
            p_cck[g] = w_cck[g];
            p_dat[g] = w_dat[g];
            p_ena[g] = w_ena[g];
        end
    end

    // ---------------- reference model --------------------------------------
    function automatic logic [63:0] exp_bits(input logic [DW-1:0] w);
        logic [63:0] r;
        r = 64'(w);
`ifdef CAL_PARITY_EN
        r = (r << 1) | 64'(^w);
`endif
        return r;
    endfunction

    function automatic int exp_len(input int div);
        return div * (2 * NB + 1);
    endfunction

    function automatic logic [63:0] nmask();
        return (64'd1 << NB) - 64'd1;
    endfunction

    // ---------------- stimulus helpers (no checking) -----------------------
    task automatic clr_mon();
        @(posedge clk); #1 mon_clr = 1'b1;
        @(negedge clk); #1 mon_clr = 1'b0;
    endtask

    task automatic start_frame(input int g, input logic [DW-1:0] w);
        @(posedge clk); #1;
        data = w;
        if (g == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
        data = DW'($urandom);
    endtask

    task automatic wait_done(input int g, input int d0, output bit to);
        int n = 0;
        while (dones[g] == d0 && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        to = (dones[g] == d0);
        @(negedge clk); #1;
    endtask

    // ---------------- scenarios ---------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            for (int g = 0; g < 2; g++) begin
                total++;
                if ({w_busy[g], w_done[g], w_cck[g], w_dat[g], w_ena[g]} !== 5'b0) begin
                    bad++;
                    $display("FAIL reset_idle dut%0d cyc%0d got=%b%b%b%b%b want=00000", g, i,
                             w_busy[g], w_done[g], w_cck[g], w_dat[g], w_ena[g]);
                end
            end
        end
    endtask

    task automatic check_frame(input string name, input int g, input logic [DW-1:0] w,
                               input int ndone, input bit to);
        int div;
        div = (g == 0) ? DIV0 : DIV1;
        total++;
        if (to) begin bad++; $display("FAIL %s timeout waiting for DONE", name); end
        total++;
        if ((rx[g] & nmask()) !== exp_bits(w)) begin
            bad++;
            $display("FAIL %s bits got=%h want=%h", name, rx[g] & nmask(), exp_bits(w));
        end
        total++;
        if (rises[g] != NB * ndone) begin
            bad++; $display("FAIL %s rises got=%0d want=%0d", name, rises[g], NB * ndone);
        end
        total++;
        if (last_run[g] != exp_len(div)) begin
            bad++; $display("FAIL %s ena_len got=%0d want=%0d", name, last_run[g], exp_len(div));
        end
        total++;
        if (dones[g] != ndone) begin
            bad++; $display("FAIL %s done_pulses got=%0d want=%0d", name, dones[g], ndone);
        end
        total++;
        if (stab_err[g] != 0) begin
            bad++; $display("FAIL %s dat_unstable_at_rise got=%0d want=0", name, stab_err[g]);
        end
        total++;
        if (w_busy[g] !== 1'b0 || w_ena[g] !== 1'b0 || w_dat[g] !== 1'b0) begin
            bad++;
            $display("FAIL %s idle_after got busy=%b ena=%b dat=%b want 000", name,
                     w_busy[g], w_ena[g], w_dat[g]);
        end
    endtask

    task automatic test_frame();
        logic [DW-1:0] w;
        bit to;
        for (int i = 0; i < 4; i++) begin
            w = (i == 0) ? 16'hA5C3 : DW'($urandom);
            clr_mon();
            start_frame(0, w);
            wait_done(0, 0, to);
            check_frame($sformatf("frame%0d", i), 0, w, 1, to);
        end
    endtask

    task automatic test_start_ignored();
        bit to;
        int n = 0;
        clr_mon();
        start_frame(0, 16'hA5C3);
        while (rises[0] < 3 && n < 500) begin @(negedge clk); #1; n++; end
        start_frame(0, 16'hFFFF);
        wait_done(0, 0, to);
        check_frame("start_ignored", 0, 16'hA5C3, 1, to);
    endtask

    task automatic test_reset_midframe();
        bit to;
        int n = 0;
        logic [DW-1:0] w;
        clr_mon();
        start_frame(0, DW'($urandom));
        while (rises[0] < 7 && n < 500) begin @(posedge clk); #1; n++; end
        total++;
        if (rises[0] != 7) begin bad++; $display("FAIL rst_mid rise7 got=%0d want=7", rises[0]); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({w_busy[0], w_done[0], w_cck[0], w_dat[0], w_ena[0]} !== 5'b0) begin
            bad++;
            $display("FAIL rst_mid async_clear got=%b%b%b%b%b want=00000",
                     w_busy[0], w_done[0], w_cck[0], w_dat[0], w_ena[0]);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        total++;
        if (dones[0] != 0) begin bad++; $display("FAIL rst_mid done_seen got=%0d want=0", dones[0]); end
        w = DW'($urandom);
        clr_mon();
        start_frame(0, w);
        wait_done(0, 0, to);
        check_frame("after_reset", 0, w, 1, to);
    endtask

    task automatic test_back_to_back();
        bit to;
        int n = 0;
        clr_mon();
        start_frame(0, DW'($urandom));
        while (w_done[0] !== 1'b1 && n < 3000) begin @(posedge clk); #1; n++; end
        data = 16'h0001;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        wait_done(0, 1, to);
        check_frame("back_to_back", 0, 16'h0001, 2, to);
        total++;
        if (last_gap[0] != 1) begin
            bad++; $display("FAIL back_to_back ena_gap got=%0d want=1", last_gap[0]);
        end
    endtask

    task automatic test_clkdiv1();
        logic [DW-1:0] w;
        bit to;
        for (int i = 0; i < 3; i++) begin
            w = (i == 0) ? 16'h8000 : DW'($urandom);
            clr_mon();
            start_frame(1, w);
            wait_done(1, 0, to);
            check_frame($sformatf("div1_%0d", i), 1, w, 1, to);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_start_ignored();
        test_reset_midframe();
        test_back_to_back();
        test_clkdiv1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cal_serial_tx.md
Name: cal_serial_tx

Overview:
- Transmitter end of the sensor's 3-wire calibration interface (CAL_CLK, CAL_DAT, CAL_ENA).
- Takes a parallel calibration word from a host and shifts it out MSB-first.
- CAL_CLK is generated by dividing the system clock.
- Sits beside the sensor core, on a host/controller tile or in the bench harness, and drives the sensor's calibration pins.

Parameters:
- DATA_W, 16: calibration word width in bits. Must be 1..32.
- CLK_DIV, 4: system clocks per CAL_CLK half-period. Must be at least 1.

Ports:
- CLK  input  1  system clock; all logic is rising-edge.
- RESET_N  input  1  asynchronous, active-low reset.
- START  input  1  single-cycle request; accepted only when BUSY=0.
- DATA  input  DATA_W  word to transmit; captured on the cycle START is accepted.
- BUSY  output  1  high from the cycle after START is accepted through the last HOLD cycle.
- DONE  output  1  one-cycle pulse in the first IDLE cycle after a frame.
- CAL_CLK  output  1  serial clock to the sensor.
- CAL_DAT  output  1  serial data; stable across every CAL_CLK rising edge.
- CAL_ENA  output  1  frame enable; high for the whole frame.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE.
  - BUSY, DONE, CAL_CLK, CAL_DAT and CAL_ENA all 0.
  - Shift register and counters cleared.
  - Reset mid-frame aborts the frame immediately; no DONE pulse.
- All outputs are registered; no combinational path from input to output.
- States: IDLE, SETUP, HIGH, LOW, HOLD. A phase counter counts CLK_DIV cycles per state except IDLE.
- IDLE:
  - CAL_ENA=0, CAL_CLK=0.
  - START=1 latches DATA into the shift register, loads bit count = DATA_W, and goes to SETUP.
- SETUP, CLK_DIV cycles:
  - CAL_ENA=1, CAL_CLK=0, CAL_DAT=MSB.
  - Then goes to HIGH.
- HIGH, CLK_DIV cycles:
  - CAL_CLK=1; the receiver samples on this rising edge.
  - Decrement the bit count.
  - If bits remain, go to LOW; otherwise go to HOLD.
- LOW, CLK_DIV cycles:
  - CAL_CLK=0.
  - CAL_DAT updates to the next bit on the first LOW cycle, i.e. half a CAL_CLK period before the next rising edge.
  - Then goes to HIGH.
- HOLD, CLK_DIV cycles:
  - CAL_CLK=0, CAL_ENA=1, CAL_DAT holds the last bit.
  - Then goes to IDLE with DONE=1 for one cycle.
  - CAL_ENA and CAL_DAT return to 0 in that same cycle.
- Frame length: CAL_ENA is high for CLK_DIV*(2*N+1) cycles, where N is the number of bits sent. Default N=16 gives 132 cycles.
- START with BUSY=1 is ignored; changes on DATA during a frame are ignored.
- Back-to-back: START in the DONE cycle is accepted. The next SETUP starts the following cycle with CAL_ENA low for exactly that one cycle, so the receiver sees a frame boundary.
- CLK_DIV=1 is legal: CAL_CLK runs at CLK/2 and DAT changes one cycle before each rise.
- Bit count and phase counter widths are derived with $clog2; no wrap inside a frame.

Optional Feature:
- Macro: CAL_PARITY_EN.
- Defined:
  - One extra bit (even parity, the XOR of all DATA_W bits) is sent after the LSB, using the same LOW/HIGH timing.
  - N=DATA_W+1; frame length is CLK_DIV*(2*DATA_W+3).
- Undefined: no parity bit, N=DATA_W, and no parity logic is synthesized.

Test Plan (defaults DATA_W=16, CLK_DIV=4 unless stated):
- Reset then idle 20 cycles -> all outputs 0 and BUSY=0 throughout.
- START with DATA=16'hA5C3 -> 16 CAL_CLK rises, bits sampled on each rise read back as A5C3 MSB-first. CAL_ENA high for 132 cycles, DONE pulses once at the end.
- START, then START again with DATA=16'hFFFF mid-frame -> second START ignored, DATA=A5C3 transmitted unchanged.
- Drop RESET_N at rise #7 -> all outputs 0 immediately, no DONE. New START after release sends the full new word.
- START asserted in the DONE cycle with DATA=16'h0001 -> CAL_ENA low for exactly 1 cycle between frames, then 0001 received.
- CAL_PARITY_EN defined, DATA=16'h0007 -> 17 rises, 17th bit=1, CAL_ENA high for 140 cycles. With CLK_DIV=1, DATA=16'h8000 -> CAL_ENA high for 33 cycles.
